// File: rtl/brightness_drain_if.sv
// Stream bundle around the drain: accumulator input from the array column and pixel output to the consumer.
// Output handshake: a pixel moves on a rising edge where out_valid && out_ready; out_pixel holds while out_valid && !out_ready.
interface brightness_drain_if #(
   parameter int ACC_WIDTH = 24,
   parameter int PIX_WIDTH = 8
) ();
   logic                 acc_valid;
   logic [ACC_WIDTH-1:0] acc_in;
   logic                 out_valid;
   logic [PIX_WIDTH-1:0] out_pixel;
   logic                 out_ready;

   // Environment side: feeds the accumulator stream and consumes pixels.
   modport master (
      output acc_valid, acc_in, out_ready,
      input  out_valid, out_pixel
   );

   // Drain side.
   modport slave (
      input  acc_valid, acc_in, out_ready,
      output out_valid, out_pixel
   );
endinterface

// File: rtl/brightness_drain.sv
// Column drain: scale + offset + clamp pipe stage, pixel FIFO with valid/ready, per-frame counting.
// Optional macro BRIGHT_ROUND_EN selects round-half-up before the right shift.
module brightness_drain #(
   parameter int ACC_WIDTH  = 24,
   parameter int PIX_WIDTH  = 8,
   parameter int SHIFT      = 0,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [CNT_WIDTH-1:0] frame_len,
   input  logic [PIX_WIDTH:0]   offset,
   brightness_drain_if.slave    bus,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 overflow,
   output logic [1:0]           dbg_state
);

   localparam int SW  = ACC_WIDTH + 2;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic [ACC_WIDTH:0]   RND      = (SHIFT > 0) ? ({{ACC_WIDTH{1'b0}}, 1'b1} << RSH) : '0;
   localparam logic signed [SW-1:0] PIX_MAX  = SW'((1 << PIX_WIDTH) - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [AW:0]          DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t state_q, state_n;
   logic                 accept;
   logic [CNT_WIDTH-1:0] len_q, cnt_q;
   logic [PIX_WIDTH:0]   off_q;

   logic                 pipe_valid;
   logic [PIX_WIDTH-1:0] pipe_pix;
   logic [ACC_WIDTH:0]   shifted;
   logic signed [SW-1:0] s_val;
   logic [PIX_WIDTH-1:0] pix_next;
   logic                 take;

   logic [PIX_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [AW:0]          fifo_cnt;
   logic                 full, pop, do_push, drop;

   // Scale, offset and clamp. The sum is wide enough that it never wraps.
   always_comb begin
`ifdef BRIGHT_ROUND_EN
      shifted = ({1'b0, bus.acc_in} + RND) >> SHIFT;
`else
      shifted = {1'b0, bus.acc_in >> SHIFT};
`endif
      s_val = $signed({1'b0, shifted}) +
              $signed({{(SW - PIX_WIDTH - 1){off_q[PIX_WIDTH]}}, off_q});
      if (s_val[SW-1]) begin
         pix_next = '0;
      end else if (s_val > PIX_MAX) begin
         pix_next = PIX_MAX[PIX_WIDTH-1:0];
      end else begin
         pix_next = s_val[PIX_WIDTH-1:0];
      end
   end

   assign take = (state_q == RUN) && bus.acc_valid;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pipe_valid <= 1'b0;
         pipe_pix   <= '0;
      end else begin
         pipe_valid <= take;
         if (take) begin
            pipe_pix <= pix_next;
         end
      end
   end

   // FIFO: a full FIFO still accepts a push when a pop happens on the same edge.
   assign full          = (fifo_cnt == DEPTH_C);
   assign bus.out_valid = (fifo_cnt != '0);
   assign bus.out_pixel = bus.out_valid ? mem[rd_ptr] : '0;
   assign pop           = bus.out_valid && bus.out_ready;
   assign do_push       = pipe_valid && (!full || pop);
   assign drop          = pipe_valid && full && !pop;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= pipe_pix;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + (AW + 1)'(1);
            2'b01:   fifo_cnt <= fifo_cnt - (AW + 1)'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   always_comb begin
      state_n    = state_q;
      accept     = 1'b0;
      frame_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && (frame_len != '0)) begin
               accept  = 1'b1;
               state_n = RUN;
            end
         end
         RUN: begin
            if (bus.acc_valid && (cnt_q == len_q - CNT_ONE)) begin
               state_n = DRAIN;
            end
         end
         DRAIN: begin
            if (!pipe_valid && (fifo_cnt == '0)) begin
               frame_done = 1'b1;
               state_n    = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Frame bookkeeping; dropped pixels still count toward the frame length.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         len_q    <= '0;
         off_q    <= '0;
         cnt_q    <= '0;
         overflow <= 1'b0;
      end else begin
         state_q <= state_n;
         if (accept) begin
            len_q    <= frame_len;
            off_q    <= offset;
            cnt_q    <= '0;
            overflow <= 1'b0;
         end else begin
            if (take) begin
               cnt_q <= cnt_q + CNT_ONE;
            end
            if (drop) begin
               overflow <= 1'b1;
            end
         end
      end
   end

   assign busy      = (state_q != IDLE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_brightness_drain.sv
// Directed bench for brightness_drain: table of single-cycle vectors plus hand sequences for
// FIFO full/overflow, simultaneous push/pop, SHIFT=2 rounding and asynchronous reset mid-frame.
module tb_brightness_drain;

   logic        clk;
   logic        reset;
   logic        start, start2;
   logic [15:0] frame_len, frame_len2;
   logic [8:0]  offset, offset2;
   logic        busy, frame_done, overflow;
   logic        busy2, frame_done2, overflow2;
   logic [1:0]  dbg_state, dbg_state2;

   int checks = 0;
   int errors = 0;

   brightness_drain_if #(.ACC_WIDTH(24), .PIX_WIDTH(8)) bus0 ();
   brightness_drain_if #(.ACC_WIDTH(24), .PIX_WIDTH(8)) bus2 ();

   brightness_drain #(.ACC_WIDTH(24), .PIX_WIDTH(8), .SHIFT(0), .FIFO_DEPTH(4), .CNT_WIDTH(16)) dut0 (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .frame_len  (frame_len),
      .offset     (offset),
      .bus        (bus0),
      .busy       (busy),
      .frame_done (frame_done),
      .overflow   (overflow),
      .dbg_state  (dbg_state)
   );

   brightness_drain #(.ACC_WIDTH(24), .PIX_WIDTH(8), .SHIFT(2), .FIFO_DEPTH(4), .CNT_WIDTH(16)) dut2 (
      .clk        (clk),
      .reset      (reset),
      .start      (start2),
      .frame_len  (frame_len2),
      .offset     (offset2),
      .bus        (bus2),
      .busy       (busy2),
      .frame_done (frame_done2),
      .overflow   (overflow2),
      .dbg_state  (dbg_state2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        start;
      logic [15:0] len;
      logic [8:0]  off;
      logic        av;
      logic [23:0] acc;
      logic        rdy;
      logic        ov;
      logic [7:0]  pix;
      logic        busy;
      logic        fd;
      logic        ovf;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic st, input int len, input int off, input logic av,
                               input int acc, input logic ov, input int pix, input logic bz,
                               input logic fd);
      vec_t v;
      v.start = st;
      v.len   = 16'(len);
      v.off   = 9'(off);
      v.av    = av;
      v.acc   = 24'(acc);
      v.rdy   = 1'b1;
      v.ov    = ov;
      v.pix   = 8'(pix);
      v.busy  = bz;
      v.fd    = fd;
      v.ovf   = 1'b0;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] exp_r6;
`ifdef BRIGHT_ROUND_EN
      exp_r6 = 8'd2;
`else
      exp_r6 = 8'd1;
`endif
      reset = 1'b0;
      start = 1'b0; frame_len = '0; offset = '0;
      start2 = 1'b0; frame_len2 = '0; offset2 = '0;
      bus0.acc_valid = 1'b0; bus0.acc_in = '0; bus0.out_ready = 1'b1;
      bus2.acc_valid = 1'b0; bus2.acc_in = '0; bus2.out_ready = 1'b1;

      // Reset state
      #12;
      check("rst_out_valid", bus0.out_valid, 0);
      check("rst_out_pixel", bus0.out_pixel, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_overflow", overflow, 0);
      check("rst_state", dbg_state, 0);
      check("rst2_out_valid", bus2.out_valid, 0);
      check("rst2_busy", busy2, 0);
      @(negedge clk);
      reset = 1'b1;
      step();

      // Frame of 3: 10, 200, 300 -> 10, 200, 255
      tbl.push_back(mk(1, 3, 0,   0, 0,   0, 0,   1, 0));
      tbl.push_back(mk(0, 3, 0,   1, 10,  0, 0,   1, 0));
      tbl.push_back(mk(0, 3, 0,   1, 200, 1, 10,  1, 0));
      tbl.push_back(mk(0, 3, 0,   1, 300, 1, 200, 1, 0));
      tbl.push_back(mk(0, 3, 0,   0, 0,   1, 255, 1, 0));
      tbl.push_back(mk(0, 3, 0,   0, 0,   0, 0,   1, 1));
      tbl.push_back(mk(0, 3, 0,   0, 0,   0, 0,   0, 0));
      // offset -20: 5 -> 0, 100 -> 80
      tbl.push_back(mk(1, 2, -20, 0, 0,   0, 0,   1, 0));
      tbl.push_back(mk(0, 2, 0,   1, 5,   0, 0,   1, 0));
      tbl.push_back(mk(0, 2, 0,   1, 100, 1, 0,   1, 0));
      tbl.push_back(mk(0, 2, 0,   0, 0,   1, 80,  1, 0));
      tbl.push_back(mk(0, 2, 0,   0, 0,   0, 0,   1, 1));
      tbl.push_back(mk(0, 2, 0,   0, 0,   0, 0,   0, 0));
      // offset +100: 200 -> 255
      tbl.push_back(mk(1, 1, 100, 0, 0,   0, 0,   1, 0));
      tbl.push_back(mk(0, 1, 0,   1, 200, 0, 0,   1, 0));
      tbl.push_back(mk(0, 1, 0,   0, 0,   1, 255, 1, 0));
      tbl.push_back(mk(0, 1, 0,   0, 0,   0, 0,   1, 1));
      tbl.push_back(mk(0, 1, 0,   0, 0,   0, 0,   0, 0));
      // frame_len = 0 is ignored
      tbl.push_back(mk(1, 0, 0,   0, 0,   0, 0,   0, 0));
      tbl.push_back(mk(0, 0, 0,   0, 0,   0, 0,   0, 0));
      // start during RUN is ignored
      tbl.push_back(mk(1, 2, 0,   0, 0,   0, 0,   1, 0));
      tbl.push_back(mk(1, 5, 0,   1, 7,   0, 0,   1, 0));
      tbl.push_back(mk(0, 5, 0,   1, 9,   1, 7,   1, 0));
      tbl.push_back(mk(0, 5, 0,   0, 0,   1, 9,   1, 0));
      tbl.push_back(mk(0, 5, 0,   0, 0,   0, 0,   1, 1));
      tbl.push_back(mk(0, 5, 0,   0, 0,   0, 0,   0, 0));

      foreach (tbl[i]) begin
         start          = tbl[i].start;
         frame_len      = tbl[i].len;
         offset         = tbl[i].off;
         bus0.acc_valid = tbl[i].av;
         bus0.acc_in    = tbl[i].acc;
         bus0.out_ready = tbl[i].rdy;
         step();
         check($sformatf("v%0d_out_valid", i), bus0.out_valid, tbl[i].ov);
         if (tbl[i].ov) check($sformatf("v%0d_out_pixel", i), bus0.out_pixel, tbl[i].pix);
         check($sformatf("v%0d_busy", i), busy, tbl[i].busy);
         check($sformatf("v%0d_frame_done", i), frame_done, tbl[i].fd);
         check($sformatf("v%0d_overflow", i), overflow, tbl[i].ovf);
      end
      start = 1'b0;
      bus0.acc_valid = 1'b0;

      // Overflow: six pixels into a 4-deep FIFO with no consumer
      bus0.out_ready = 1'b0;
      start = 1'b1; frame_len = 16'd6; offset = '0;
      step();
      start = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         bus0.acc_valid = 1'b1; bus0.acc_in = 24'(k);
         step();
      end
      bus0.acc_valid = 1'b0;
      check("ovf_set", overflow, 1);
      check("ovf_state_drain", dbg_state, 2);
      step(); step();
      check("ovf_hold_state", dbg_state, 2);
      check("ovf_hold_valid", bus0.out_valid, 1);
      check("ovf_hold_pixel", bus0.out_pixel, 1);
      bus0.out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("ovf_pop%0d", k), bus0.out_pixel, k);
         step();
      end
      check("ovf_empty", bus0.out_valid, 0);
      check("ovf_frame_done", frame_done, 1);
      step();
      check("ovf_idle", busy, 0);
      check("ovf_done_pulse", frame_done, 0);
      check("ovf_sticky", overflow, 1);

      // Full FIFO with push and pop on the same edge
      bus0.out_ready = 1'b0;
      start = 1'b1; frame_len = 16'd5; offset = '0;
      step();
      start = 1'b0;
      check("full_ovf_cleared", overflow, 0);
      for (int k = 0; k < 5; k++) begin
         bus0.acc_valid = 1'b1; bus0.acc_in = 24'(11 + k);
         step();
      end
      bus0.acc_valid = 1'b0;
      check("full_head", bus0.out_pixel, 11);
      bus0.out_ready = 1'b1;
      step();
      bus0.out_ready = 1'b0;
      check("full_pp_ovf", overflow, 0);
      check("full_pp_head", bus0.out_pixel, 12);
      step(); step();
      check("full_stable_pixel", bus0.out_pixel, 12);
      check("full_stable_valid", bus0.out_valid, 1);
      check("full_stable_state", dbg_state, 2);
      bus0.out_ready = 1'b1;
      for (int k = 12; k <= 15; k++) begin
         check($sformatf("full_pop_%0d", k), bus0.out_pixel, k);
         step();
      end
      check("full_empty", bus0.out_valid, 0);
      check("full_ovf_end", overflow, 0);
      check("full_frame_done", frame_done, 1);
      step();

      // SHIFT=2: 6 -> 1 (truncate) or 2 (rounded); 5 -> 1
      start2 = 1'b1; frame_len2 = 16'd2; offset2 = '0;
      step();
      start2 = 1'b0;
      bus2.acc_valid = 1'b1; bus2.acc_in = 24'd6;
      step();
      bus2.acc_in = 24'd5;
      step();
      bus2.acc_valid = 1'b0;
      check("sh2_valid", bus2.out_valid, 1);
      check("sh2_pix6", bus2.out_pixel, exp_r6);
      step();
      check("sh2_pix5", bus2.out_pixel, 1);
      step();
      check("sh2_empty", bus2.out_valid, 0);
      check("sh2_frame_done", frame_done2, 1);
      step();
      check("sh2_idle", busy2, 0);

      // Asynchronous reset mid-RUN with two pixels buffered
      bus0.out_ready = 1'b0;
      start = 1'b1; frame_len = 16'd5; offset = '0;
      step();
      start = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         bus0.acc_valid = 1'b1; bus0.acc_in = 24'(k);
         step();
      end
      bus0.acc_valid = 1'b0;
      check("arst_pre_valid", bus0.out_valid, 1);
      check("arst_pre_state", dbg_state, 1);
      #2;
      reset = 1'b0;
      #1;
      check("arst_valid", bus0.out_valid, 0);
      check("arst_busy", busy, 0);
      check("arst_state", dbg_state, 0);
      @(negedge clk);
      reset = 1'b1;
      step(); step();
      check("arst_post_valid", bus0.out_valid, 0);
      check("arst_post_busy", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
